uart_rx_frame_ctrl: RTL and testbench

- Sequences the UART_RX byte datapath into framed packets; sits directly downstream of UART_RX and upstream of the packet consumer.
- Gates UART_RX via rx_en, parses frames of the form SOF (0x7E), LEN, LEN payload bytes, CRC-8, and streams the payload out.
- Checks CRC-8 (poly 0x07, init 0x00, no reflection, no xorout) over LEN and payload.
- Aborts on inter-byte timeout, measured in 16x oversample ticks.

---
 rtl/uart_rx_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer behind UART_RX: parses SOF/LEN/payload/CRC-8 frames, streams the payload,
// and reports completion, CRC/length errors, and inter-byte timeout or disable aborts.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SOF_BYTE      = 8'h7E,
  parameter int unsigned MAX_LEN       = 64,
  parameter int unsigned TIMEOUT_TICKS = 480
) (
  input  logic       clk_master,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       tick_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  output logic       rx_en_o,
  output logic [7:0] pl_data_o,
  output logic       pl_valid_o,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);

  localparam int unsigned      TmoW    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0]       MaxLen  = 8'(MAX_LEN);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StLen, StPayload, StCrc} state_e;

  state_e          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      crc_q, crc_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic tick_q, done_q, armed_q;
  logic tick_ev, byte_ev;

  logic pl_fire, crc_ok, crc_bad, len_err, abort;

  logic [7:0] pl_data_d;
  logic       pl_valid_d, frame_ok_d, frame_err_d;
  logic [1:0] err_code_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // armed_q masks the first cycle after reset so a level already high is not taken as an edge
  always_ff @(posedge clk_master or posedge rst_i) begin
    if (rst_i) begin
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      tick_q  <= tick_i;
      done_q  <= rx_done_i;
      armed_q <= 1'b1;
    end
  end

  assign tick_ev = armed_q & tick_i & ~tick_q;
  assign byte_ev = armed_q & enable_i & rx_done_i & ~done_q;

  always_ff @(posedge clk_master or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    tmo_d   = tmo_q;
    pl_fire = 1'b0;
    crc_ok  = 1'b0;
    crc_bad = 1'b0;
    len_err = 1'b0;
    abort   = 1'b0;
    if (state_q == StIdle) begin
      tmo_d = '0;
      if (byte_ev && rx_data_i == SOF_BYTE) begin
        state_d = StLen;
        crc_d   = 8'h00;
      end
    end else if (!enable_i) begin
      abort   = 1'b1;
      state_d = StIdle;
      tmo_d   = '0;
    end else if (byte_ev) begin
      // A byte beats a coincident tick: the counter clears and the byte is consumed
      tmo_d = '0;
      case (state_q)
        StLen: begin
          len_d = rx_data_i;
          crc_d = crc8_step(8'h00, rx_data_i);
          if (rx_data_i > MaxLen) begin
            len_err = 1'b1;
            state_d = StIdle;
          end else if (rx_data_i == 8'h00) begin
            state_d = StCrc;
          end else begin
            state_d = StPayload;
            cnt_d   = 8'h00;
          end
        end
        StPayload: begin
          pl_fire = 1'b1;
          crc_d   = crc8_step(crc_q, rx_data_i);
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) state_d = StCrc;
        end
        StCrc: begin
          crc_ok  = (rx_data_i == crc_q);
          crc_bad = (rx_data_i != crc_q);
          state_d = StIdle;
        end
        default: ;
      endcase
    end else if (tick_ev) begin
      if (tmo_q == TmoLast) begin
        abort   = 1'b1;
        state_d = StIdle;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_comb begin
    pl_valid_d  = pl_fire;
    pl_data_d   = pl_fire ? rx_data_i : pl_data_o;
    frame_ok_d  = crc_ok;
    frame_err_d = crc_bad | len_err | abort;
    err_code_d  = err_code_o;
    if (crc_ok)       err_code_d = 2'b00;
    else if (crc_bad) err_code_d = 2'b01;
    else if (len_err) err_code_d = 2'b10;
    else if (abort)   err_code_d = 2'b11;
  end

  always_ff @(posedge clk_master or posedge rst_i) begin
    if (rst_i) begin
      rx_en_o     <= 1'b0;
      pl_data_o   <= '0;
      pl_valid_o  <= 1'b0;
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
      err_code_o  <= '0;
    end else begin
      rx_en_o     <= enable_i;
      pl_data_o   <= pl_data_d;
      pl_valid_o  <= pl_valid_d;
      frame_ok_o  <= frame_ok_d;
      frame_err_o <= frame_err_d;
      err_code_o  <= err_code_d;
    end
  end

  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed and random byte streams checked against a
// frame-level model (byte queue per frame, serial CRC-8 division, tick counting).
module tb_uart_rx_frame_ctrl;

  localparam int MaxLen   = 64;
  localparam int TmoTicks = 480;
  localparam int ResOk    = 4;

  logic       clk_master = 1'b0;
  logic       rst_i      = 1'b1;
  logic       enable_i   = 1'b1;
  logic       tick_i     = 1'b0;
  logic [7:0] rx_data_i  = 8'h7E;
  logic       rx_done_i  = 1'b1;
  logic       rx_en_o;
  logic [7:0] pl_data_o;
  logic       pl_valid_o;
  logic       frame_ok_o;
  logic       frame_err_o;
  logic [1:0] err_code_o;
  logic       busy_o;

  uart_rx_frame_ctrl #(
    .SOF_BYTE      (8'h7E),
    .MAX_LEN       (MaxLen),
    .TIMEOUT_TICKS (TmoTicks)
  ) dut (
    .clk_master  (clk_master),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .tick_i      (tick_i),
    .rx_data_i   (rx_data_i),
    .rx_done_i   (rx_done_i),
    .rx_en_o     (rx_en_o),
    .pl_data_o   (pl_data_o),
    .pl_valid_o  (pl_valid_o),
    .frame_ok_o  (frame_ok_o),
    .frame_err_o (frame_err_o),
    .err_code_o  (err_code_o),
    .busy_o      (busy_o)
  );

  always #5 clk_master = ~clk_master;

  int n_checks = 0;
  int n_errors = 0;
  int coincide = 0;

  int exp_pl[$];
  int obs_pl[$];
  int exp_res[$];
  int obs_res[$];

  bit         m_busy  = 1'b0;
  int         m_ticks = 0;
  int         m_last  = 0;
  int         m_frame[$];
  logic [7:0] stim[$];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame results: 4 = good frame, otherwise the error code reported with frame_err_o
  always @(negedge clk_master) begin
    if (!rst_i) begin
      if (pl_valid_o) obs_pl.push_back(int'(pl_data_o));
      if (frame_ok_o) obs_res.push_back(ResOk);
      if (frame_err_o) obs_res.push_back(int'(err_code_o));
      if ((pl_valid_o && (frame_ok_o || frame_err_o)) || (frame_ok_o && frame_err_o))
        coincide++;
    end
  end

  // Reference CRC-8 as bit-serial polynomial division, MSB first
  function automatic logic [7:0] crc_step(input logic [7:0] r, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
    c = r;
    for (int k = 7; k >= 0; k--) begin
      fb = c[7] ^ b[k];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic m_close(input int code);
    exp_res.push_back(code);
    m_last = (code == ResOk) ? 0 : code;
    m_busy = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    int         sz;
    int         len;
    logic [7:0] r;
    if (!m_busy) begin
      if (b == 8'h7E) begin
        m_busy  = 1'b1;
        m_ticks = 0;
        m_frame.delete();
      end
    end else begin
      m_ticks = 0;
      m_frame.push_back(int'(b));
      sz  = m_frame.size();
      len = m_frame[0];
      if (sz == 1) begin
        if (len > MaxLen) m_close(2);
      end else if (sz <= len + 1) begin
        exp_pl.push_back(int'(b));
      end else begin
        r = 8'h00;
        for (int i = 0; i < sz - 1; i++) r = crc_step(r, 8'(m_frame[i]));
        m_close((r == b) ? ResOk : 1);
      end
    end
  endtask

  task automatic m_tick();
    if (m_busy) begin
      m_ticks++;
      if (m_ticks == TmoTicks) m_close(3);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit with_tick);
    @(negedge clk_master);
    rx_data_i = b;
    rx_done_i = 1'b1;
    tick_i    = with_tick;
    @(negedge clk_master);
    rx_done_i = 1'b0;
    tick_i    = 1'b0;
    if (enable_i) m_byte(b);
  endtask

  task automatic send_stim();
    foreach (stim[i]) send(stim[i], 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_master);
      tick_i = 1'b1;
      @(negedge clk_master);
      tick_i = 1'b0;
      m_tick();
    end
  endtask

  task automatic drop_enable();
    @(negedge clk_master);
    enable_i = 1'b0;
    if (m_busy) m_close(3);
    @(negedge clk_master);
    check_val("rx_en_off", int'(rx_en_o), 0);
    repeat (3) @(negedge clk_master);
    enable_i = 1'b1;
  endtask

  task automatic settle(input string tag);
    repeat (4) @(negedge clk_master);
    check_val({tag, "_pl_count"}, obs_pl.size(), exp_pl.size());
    for (int i = 0; i < exp_pl.size() && i < obs_pl.size(); i++)
      check_val($sformatf("%s_pl%0d", tag, i), obs_pl[i], exp_pl[i]);
    check_val({tag, "_res_count"}, obs_res.size(), exp_res.size());
    for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++)
      check_val($sformatf("%s_res%0d", tag, i), obs_res[i], exp_res[i]);
    check_val({tag, "_busy"}, int'(busy_o), int'(m_busy));
    check_val({tag, "_err_code"}, int'(err_code_o), m_last);
    check_val({tag, "_rx_en"}, int'(rx_en_o), int'(enable_i));
    exp_pl.delete();
    obs_pl.delete();
    exp_res.delete();
    obs_res.delete();
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_rx_en"}, int'(rx_en_o), 0);
    check_val({tag, "_pl_valid"}, int'(pl_valid_o), 0);
    check_val({tag, "_frame_ok"}, int'(frame_ok_o), 0);
    check_val({tag, "_frame_err"}, int'(frame_err_o), 0);
    check_val({tag, "_busy"}, int'(busy_o), 0);
    check_val({tag, "_pl_data"}, int'(pl_data_o), 0);
    check_val({tag, "_err_code"}, int'(err_code_o), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         len;
    logic [7:0] b;
    logic [7:0] crc;
    int         stall_at;

    // Reset held with a SOF byte already signalled; it must not start a frame
    #2;
    check_reset("reset");
    @(negedge clk_master);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_master);
    rx_done_i = 1'b0;
    @(negedge clk_master);
    check_val("no_byte_at_reset", int'(busy_o), 0);

    stim = '{8'h7E, 8'h01, 8'h00, 8'h15};
    send_stim();
    settle("basic_ok");

    stim = '{8'h7E, 8'h00, 8'h00};
    send_stim();
    settle("zero_len");

    stim = '{8'h7E, 8'h01, 8'h00, 8'h16};
    send_stim();
    settle("bad_crc");

    stim = '{8'h41, 8'h42, 8'h7E, 8'h01, 8'h00, 8'h15};
    send_stim();
    settle("garbage_then_ok");

    stim = '{8'h7E, 8'h41};
    send_stim();
    settle("len_too_big");

    stim = '{8'h7E, 8'h02, 8'hAA};
    send_stim();
    ticks(TmoTicks);
    settle("timeout");

    stim = '{8'h7E, 8'h02, 8'hAA};
    send_stim();
    ticks(TmoTicks - 1);
    send(8'hBB, 1'b0);
    send(crc_step(crc_step(crc_step(8'h00, 8'h02), 8'hAA), 8'hBB), 1'b0);
    settle("stall_479");

    stim = '{8'h7E, 8'h01};
    send_stim();
    ticks(TmoTicks - 1);
    send(8'h00, 1'b1);
    send(8'h15, 1'b0);
    settle("byte_vs_tick");

    stim = '{8'h7E, 8'h03};
    send_stim();
    drop_enable();
    settle("disable_abort");

    @(negedge clk_master);
    enable_i = 1'b0;
    stim = '{8'h7E, 8'h00, 8'h00};
    send_stim();
    enable_i = 1'b1;
    settle("disabled_bytes");

    stim = '{8'h7E, 8'h02, 8'h11};
    send_stim();
    settle("pre_reset");
    @(negedge clk_master);
    rst_i = 1'b1;
    #1;
    check_reset("mid_reset");
    m_busy = 1'b0;
    m_last = 0;
    @(negedge clk_master);
    rst_i = 1'b0;
    stim = '{8'h7E, 8'h01, 8'h00, 8'h15};
    send_stim();
    settle("after_reset");

    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h7E) b = 8'h7F;
        send(b, $urandom_range(0, 3) == 0);
      end
      send(8'h7E, $urandom_range(0, 3) == 0);
      len      = $urandom_range(0, 70);
      stall_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      send(8'(len), 1'b0);
      crc = crc_step(8'h00, 8'(len));
      if (len <= MaxLen) begin
        for (int i = 0; i <= len; i++) begin
          ticks($urandom_range(0, 2));
          if (i == stall_at) ticks($urandom_range(TmoTicks - 4, TmoTicks + 2));
          if (i < len) begin
            b   = 8'($urandom_range(0, 255));
            crc = crc_step(crc, b);
          end else begin
            b = ($urandom_range(0, 3) == 0) ? (crc ^ 8'($urandom_range(1, 255))) : crc;
          end
          send(b, $urandom_range(0, 4) == 0);
        end
      end
      settle($sformatf("rand%0d", f));
      if (m_busy) begin
        drop_enable();
        settle($sformatf("rand%0d_abort", f));
      end
    end

    check_val("strobe_overlap", coincide, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
